imem_loader: RTL and testbench

Boot-time writer for the instruction memory that the pipeline fetch stage reads. Accepts a framed byte stream (length header, big-endian instruction words, XOR checksum) over a valid/ready byte interface. Writes each assembled 32-bit word into instruction memory at consecutive word addresses. Holds the core pipeline in reset until a frame completes with a correct checksum.

---
 rtl/imem_loader.sv | 190 +++++++++++++++++++
 tb/tb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory writer fed by a framed byte stream.
// Latency: write strobe, done and err are registered one cycle after the deciding byte.
// Backpressure: il_o_ready is high only while the frame is being consumed; stalls leave state unchanged.
//
// Frame: 16-bit word count N (MSB first), 4N data bytes (words MSB first), one XOR checksum byte
// covering the data bytes only.
// Ports:
//   il_clk, il_rst              clock, asynchronous active-high reset
//   il_i_start                  one-cycle pulse, begins a load from IDLE/DONE/ERR
//   il_i_valid/il_i_byte        byte stream in, il_o_ready accepts
//   il_o_we/il_o_addr/il_o_wdata registered instruction memory write port
//   il_o_hold                   keeps the core in reset until a good frame completes
//   il_o_done/il_o_err          sticky load outcome
module imem_loader #(
    parameter int                  IWIDTH    = 32,
    parameter int                  PC_WIDTH  = 32,
    parameter int                  DEPTH     = 1024,
    parameter logic [PC_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                il_clk,
    input  logic                il_rst,
    input  logic                il_i_start,
    input  logic                il_i_valid,
    input  logic [7:0]          il_i_byte,
    output logic                il_o_ready,
    output logic                il_o_we,
    output logic [PC_WIDTH-1:0] il_o_addr,
    output logic [IWIDTH-1:0]   il_o_wdata,
    output logic                il_o_hold,
    output logic                il_o_done,
    output logic                il_o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t              r_state;
    state_t              w_next;

    logic [7:0]          r_len_hi;
    logic [15:0]         r_len;
    logic [15:0]         r_idx;
    logic [1:0]          r_bcnt;
    logic [23:0]         r_shift;
    logic [7:0]          r_xor;
    logic                r_we;
    logic [PC_WIDTH-1:0] r_addr;
    logic [IWIDTH-1:0]   r_wdata;
    logic                r_hold;
    logic                r_done;
    logic                r_err;

    logic                w_accept;
    logic                w_start_ok;
    logic [15:0]         w_len;
    logic                w_len_big;
    logic                w_last_byte;
    logic                w_last_word;
    logic [31:0]         w_word;

    assign w_accept    = il_i_valid && il_o_ready;
    assign w_start_ok  = il_i_start &&
                         (r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_len       = {r_len_hi, il_i_byte};
    assign w_len_big   = (32'(w_len) > 32'(DEPTH));
    assign w_last_byte = (r_bcnt == 2'd3);
    // r_len >= 1 whenever DATA is entered, so N-1 never underflows here.
    assign w_last_word = (r_idx == r_len - 16'd1);
    assign w_word      = {r_shift, il_i_byte};

    always_ff @(posedge il_clk or posedge il_rst) begin
        if (il_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        il_o_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (il_i_start) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                il_o_ready = 1'b1;
                if (w_accept) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                il_o_ready = 1'b1;
                if (w_accept) begin
                    if (w_len_big)          w_next = S_ERR;
                    else if (w_len == 16'd0) w_next = S_CHECK;
                    else                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                il_o_ready = 1'b1;
                if (w_accept && w_last_byte && w_last_word) w_next = S_CHECK;
            end
            S_CHECK: begin
                il_o_ready = 1'b1;
                if (w_accept) w_next = (il_i_byte == r_xor) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (il_i_start) w_next = S_LEN_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge il_clk or posedge il_rst) begin
        if (il_rst) begin
            r_len_hi <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_bcnt   <= '0;
            r_shift  <= '0;
            r_xor    <= '0;
            r_we     <= 1'b0;
            r_addr   <= BASE_ADDR;
            r_wdata  <= '0;
            r_hold   <= 1'b1;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_we <= 1'b0;
            // A new load re-arms hold and clears the per-frame bookkeeping.
            if (w_start_ok) begin
                r_done <= 1'b0;
                r_err  <= 1'b0;
                r_hold <= 1'b1;
                r_idx  <= '0;
                r_xor  <= '0;
                r_bcnt <= '0;
            end
            case (r_state)
                S_LEN_HI: begin
                    if (w_accept) r_len_hi <= il_i_byte;
                end
                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        if (w_len_big) r_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_accept) begin
                        r_xor   <= r_xor ^ il_i_byte;
                        r_shift <= w_word[23:0];
                        r_bcnt  <= r_bcnt + 2'd1;
                        if (w_last_byte) begin
                            r_we    <= 1'b1;
                            r_wdata <= IWIDTH'(w_word);
                            r_addr  <= BASE_ADDR + (PC_WIDTH'(r_idx) << 2);
                            r_idx   <= r_idx + 16'd1;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_accept) begin
                        if (il_i_byte == r_xor) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign il_o_we    = r_we;
    assign il_o_addr  = r_addr;
    assign il_o_wdata = r_wdata;
    assign il_o_hold  = r_hold;
    assign il_o_done  = r_done;
    assign il_o_err   = r_err;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames against a byte-position model of the frame format.
// Latency: model predicts outputs one cycle after each accepted byte.
// Backpressure: driver holds a byte until ready is seen, with optional idle gaps.
module tb_imem_loader;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0;

    logic        il_clk;
    logic        il_rst;
    logic        il_i_start;
    logic        il_i_valid;
    logic [7:0]  il_i_byte;
    logic        il_o_ready;
    logic        il_o_we;
    logic [31:0] il_o_addr;
    logic [31:0] il_o_wdata;
    logic        il_o_hold;
    logic        il_o_done;
    logic        il_o_err;

    imem_loader #(
        .IWIDTH   (32),
        .PC_WIDTH (32),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE)
    ) dut (
        .il_clk    (il_clk),
        .il_rst    (il_rst),
        .il_i_start(il_i_start),
        .il_i_valid(il_i_valid),
        .il_i_byte (il_i_byte),
        .il_o_ready(il_o_ready),
        .il_o_we   (il_o_we),
        .il_o_addr (il_o_addr),
        .il_o_wdata(il_o_wdata),
        .il_o_hold (il_o_hold),
        .il_o_done (il_o_done),
        .il_o_err  (il_o_err)
    );

    initial il_clk = 1'b0;
    always #5 il_clk = ~il_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Model of the frame: everything is derived from the position of each accepted byte.
    logic        m_busy;
    int          m_pos;
    int          m_n;
    logic [7:0]  m_hi;
    logic [7:0]  m_xor;
    logic [31:0] m_word;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_done;
    logic        m_err;

    int          we_cnt = 0;
    logic [31:0] cap_addr [64];
    logic [31:0] cap_data [64];

    initial begin
        m_busy = 1'b0; m_pos = 0; m_n = 0; m_hi = '0; m_xor = '0; m_word = '0;
        m_we = 1'b0; m_addr = BASE; m_wdata = '0; m_done = 1'b0; m_err = 1'b0;
    end

    always @(negedge il_clk) begin
        if (il_rst) begin
            m_busy = 1'b0; m_we = 1'b0; m_addr = BASE; m_wdata = '0;
            m_done = 1'b0; m_err = 1'b0;
        end
        chk("ready", 32'(il_o_ready), 32'(m_busy));
        chk("we",    32'(il_o_we),    32'(m_we));
        if (m_we) begin
            chk("addr",  il_o_addr,  m_addr);
            chk("wdata", il_o_wdata, m_wdata);
        end
        chk("done", 32'(il_o_done), 32'(m_done));
        chk("err",  32'(il_o_err),  32'(m_err));
        chk("hold", 32'(il_o_hold), 32'(!m_done));
        if (il_o_we) begin
            if (we_cnt < 64) begin
                cap_addr[we_cnt] = il_o_addr;
                cap_data[we_cnt] = il_o_wdata;
            end
            we_cnt++;
        end
        // Predict the outputs after the coming rising edge.
        m_we = 1'b0;
        if (!il_rst) begin
            if (!m_busy) begin
                if (il_i_start) begin
                    m_busy = 1'b1; m_pos = 0; m_done = 1'b0; m_err = 1'b0; m_xor = '0;
                end
            end else if (il_i_valid) begin
                if (m_pos == 0) begin
                    m_hi = il_i_byte;
                end else if (m_pos == 1) begin
                    m_n = int'({m_hi, il_i_byte});
                    if (m_n > DEPTH) begin
                        m_busy = 1'b0;
                        m_err  = 1'b1;
                    end
                end else if (m_pos == 2 + 4 * m_n) begin
                    m_busy = 1'b0;
                    if (il_i_byte == m_xor) m_done = 1'b1;
                    else                    m_err  = 1'b1;
                end else begin
                    m_xor  = m_xor ^ il_i_byte;
                    m_word = {m_word[23:0], il_i_byte};
                    if ((m_pos - 2) % 4 == 3) begin
                        m_we    = 1'b1;
                        m_wdata = m_word;
                        m_addr  = BASE + 32'(4 * ((m_pos - 2) / 4));
                    end
                end
                m_pos++;
            end
        end
    end

    logic [7:0] frame [$];

    task automatic pulse_start();
        il_i_start = 1'b1;
        @(posedge il_clk); #1;
        il_i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        il_i_valid = 1'b0;
        repeat (gap) begin @(posedge il_clk); #1; end
        il_i_valid = 1'b1;
        il_i_byte  = b;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge il_clk);
            if (il_o_ready) begin
                @(posedge il_clk); #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not_accepted required=accepted byte=%h", b);
        end
        il_i_valid = 1'b0;
    endtask

    task automatic send_frame(input int maxgap, input int count);
        for (int i = 0; i < count && i < frame.size(); i++)
            send_byte(frame[i], (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    endtask

    task automatic load_good();
        // XOR of the eight data bytes is 0x55.
        frame = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20, 8'h55};
    endtask

    task automatic check_good_writes(input string tag, input int base);
        chk({tag, "_pulses"}, 32'(we_cnt - base), 32'd2);
        chk({tag, "_addr0"},  cap_addr[base],     32'h0000_0000);
        chk({tag, "_data0"},  cap_data[base],     32'h2008_0005);
        chk({tag, "_addr1"},  cap_addr[base + 1], 32'h0000_0004);
        chk({tag, "_data1"},  cap_data[base + 1], 32'h0109_5020);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    int base;

    initial begin
        il_rst = 1'b1; il_i_start = 1'b0; il_i_valid = 1'b0; il_i_byte = '0;
        repeat (3) @(posedge il_clk);
        #1 il_rst = 1'b0;
        @(posedge il_clk); #1;
        chk("rst_hold",  32'(il_o_hold),  32'd1);
        chk("rst_ready", 32'(il_o_ready), 32'd0);
        chk("rst_we",    32'(il_o_we),    32'd0);
        chk("rst_done",  32'(il_o_done),  32'd0);
        chk("rst_err",   32'(il_o_err),   32'd0);
        chk("rst_addr",  il_o_addr,       BASE);
        chk("rst_wdata", il_o_wdata,      32'd0);

        // Good frame, contiguous bytes.
        base = we_cnt;
        load_good();
        pulse_start();
        send_frame(0, 11);
        chk("good_done", 32'(il_o_done), 32'd1);
        chk("good_hold", 32'(il_o_hold), 32'd0);
        chk("good_err",  32'(il_o_err),  32'd0);
        check_good_writes("good", base);

        // Same frame with idle gaps; start out of DONE reasserts hold.
        base = we_cnt;
        pulse_start();
        chk("restart_hold", 32'(il_o_hold), 32'd1);
        chk("restart_done", 32'(il_o_done), 32'd0);
        send_frame(3, 11);
        chk("gap_done", 32'(il_o_done), 32'd1);
        check_good_writes("gap", base);
        repeat (2) @(posedge il_clk); #1;
        chk("gap_ready_after", 32'(il_o_ready), 32'd0);

        // Bad checksum.
        base = we_cnt;
        load_good();
        frame[10] = 8'h5D;
        pulse_start();
        send_frame(0, 11);
        check_good_writes("bad", base);
        chk("bad_err",  32'(il_o_err),  32'd1);
        chk("bad_hold", 32'(il_o_hold), 32'd1);
        chk("bad_done", 32'(il_o_done), 32'd0);

        // N = 0 with checksum 0.
        base = we_cnt;
        frame = '{8'h00, 8'h00, 8'h00};
        pulse_start();
        send_frame(0, 3);
        chk("n0_done",   32'(il_o_done),     32'd1);
        chk("n0_pulses", 32'(we_cnt - base), 32'd0);

        // N = DEPTH + 1 = 0x0401.
        base = we_cnt;
        frame = '{8'h04, 8'h01};
        pulse_start();
        send_frame(0, 2);
        chk("big_err", 32'(il_o_err), 32'd1);
        repeat (3) @(posedge il_clk); #1;
        chk("big_ready",  32'(il_o_ready),    32'd0);
        chk("big_pulses", 32'(we_cnt - base), 32'd0);

        // Abort after the sixth data byte, then a clean reload.
        base = we_cnt;
        load_good();
        pulse_start();
        send_frame(0, 8);
        il_rst = 1'b1;
        repeat (4) @(posedge il_clk); #1;
        chk("abort_pulses", 32'(we_cnt - base), 32'd1);
        chk("abort_hold",   32'(il_o_hold),     32'd1);
        chk("abort_ready",  32'(il_o_ready),    32'd0);
        chk("abort_addr",   il_o_addr,          BASE);
        il_rst = 1'b0;
        @(posedge il_clk); #1;
        base = we_cnt;
        pulse_start();
        send_frame(0, 11);
        chk("reload_done", 32'(il_o_done), 32'd1);
        check_good_writes("reload", base);

        repeat (3) @(posedge il_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
